// File: rtl/matrix_line_buffer_pkg.sv
// Shared constants and types for the 3x3 window producer and the matrix operators.
// Frame geometry defaults and the common 9-bit counter width live here.
package matrix_line_buffer_pkg;

    localparam int WIDTH_DEF      = 24;
    localparam int PIC_WIDTH_DEF  = 480;
    localparam int PIC_HEIGHT_DEF = 272;
    localparam int CNT_W          = 9;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic valid;
        logic eol;
        logic eof;
    } flags_t;

    // Increment with wrap to zero after 'last'.
    function automatic cnt_t cnt_wrap(input cnt_t v, input cnt_t last);
        return (v == last) ? '0 : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/matrix_line_buffer_line_ram.sv
// Single-port line memory with a registered read port.
// A write to the addressed word returns the old contents on the same cycle.
module line_ram #(
    parameter int DEPTH  = 480,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/matrix_line_buffer.sv
// Raster stream to three vertically aligned rows (r-2, r-1, r) for 3x3 operators.
// Counters, row gating and the two line memories sit here; outputs lag input by one clock.
module matrix_line_buffer
    import matrix_line_buffer_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
    parameter int PIC_HEIGHT = PIC_HEIGHT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] pixel_in,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             valid_out,
    output logic             eol_out,
    output logic             eof_out
);

    localparam int AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

    cnt_t             col_q, col_d, row_q, row_d;
    cnt_t             col_eff, row_eff;
    flags_t           flags_q, flags_d;
    logic [WIDTH-1:0] dout3_q;
    logic             sel_q;
    logic             last_col, last_row;
    logic             ram_en;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] rd_data [2];

    // A start-of-frame pixel is processed as if the counters were already zero.
    always_comb begin
        col_eff  = sof_in ? '0 : col_q;
        row_eff  = sof_in ? '0 : row_q;
        last_col = (col_eff == cnt_t'(PIC_WIDTH - 1));
        last_row = (row_eff == cnt_t'(PIC_HEIGHT - 1));
        ram_en   = valid_in && !rst;
        ram_addr = AW'(col_eff);

        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            col_d = cnt_wrap(col_eff, cnt_t'(PIC_WIDTH - 1));
            row_d = last_col ? cnt_wrap(row_eff, cnt_t'(PIC_HEIGHT - 1)) : row_eff;
        end else if (sof_in) begin
            col_d = '0;
            row_d = '0;
        end

        flags_d.valid = valid_in && (row_eff >= cnt_t'(2));
        flags_d.eol   = flags_d.valid && last_col;
        flags_d.eof   = valid_in && last_col && last_row;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            flags_q <= '0;
            dout3_q <= '0;
            sel_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            flags_q <= flags_d;
            if (valid_in) begin
                dout3_q <= pixel_in;
                sel_q   <= row_eff[0];
            end
        end
    end

    // The two lines ping-pong by row parity: each row overwrites the memory holding
    // row r-2 after reading it, which gives the same outputs as shifting lineB into
    // lineA while needing only one port per memory.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            line_ram #(
                .DEPTH (PIC_WIDTH),
                .WIDTH (WIDTH),
                .ADDR_W(AW)
            ) u_line (
                .clk    (clk),
                .srst   (rst),
                .en_i   (ram_en),
                .we_i   (row_eff[0] == 1'(gi)),
                .addr_i (ram_addr),
                .wdata_i(pixel_in),
                .rdata_o(rd_data[gi])
            );
        end
    endgenerate

    assign dout1     = sel_q ? rd_data[1] : rd_data[0];
    assign dout2     = sel_q ? rd_data[0] : rd_data[1];
    assign dout3     = dout3_q;
    assign valid_out = flags_q.valid;
    assign eol_out   = flags_q.eol;
    assign eof_out   = flags_q.eof;

endmodule

// File: tb/tb_matrix_line_buffer.sv
// Directed table-driven bench for matrix_line_buffer on a 4x4 frame.
// Each vector drives one clock and lists the outputs expected one cycle later.
module tb_matrix_line_buffer;

    localparam int W  = 24;
    localparam int PW = 4;
    localparam int PH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sof_in = 1'b0;
    logic         valid_in = 1'b0;
    logic [W-1:0] pixel_in = '0;
    logic [W-1:0] dout1, dout2, dout3;
    logic         valid_out, eol_out, eof_out;

    always #5 clk = ~clk;

    matrix_line_buffer #(
        .WIDTH     (W),
        .PIC_WIDTH (PW),
        .PIC_HEIGHT(PH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sof_in   (sof_in),
        .valid_in (valid_in),
        .pixel_in (pixel_in),
        .dout1    (dout1),
        .dout2    (dout2),
        .dout3    (dout3),
        .valid_out(valid_out),
        .eol_out  (eol_out),
        .eof_out  (eof_out)
    );

    typedef struct {
        logic         rst;
        logic         sof;
        logic         valid;
        logic [W-1:0] pix;
        logic         e_valid;
        logic         e_eol;
        logic         e_eof;
        logic         chk3;
        logic         chk12;
        logic [W-1:0] e_d1;
        logic [W-1:0] e_d2;
        logic [W-1:0] e_d3;
    } vec_t;

    vec_t         vecs[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] frame_mem [PH][PW];
    logic [W-1:0] last_d1 = '0, last_d2 = '0, last_d3 = '0;
    logic         last_chk3 = 1'b1, last_chk12 = 1'b1;

    // Accepted pixel at logical (r, c) of the current frame.
    function automatic void add_pix(input bit sof, input int r, input int c, input int pv);
        vec_t v;
        v.rst     = 1'b0;
        v.sof     = sof;
        v.valid   = 1'b1;
        v.pix     = W'(pv);
        v.e_valid = (r >= 2);
        v.e_eol   = (r >= 2) && (c == PW - 1);
        v.e_eof   = (r == PH - 1) && (c == PW - 1);
        v.chk3    = 1'b1;
        v.e_d3    = W'(pv);
        v.chk12   = (r >= 2);
        v.e_d1    = (r >= 2) ? frame_mem[r-2][c] : '0;
        v.e_d2    = (r >= 2) ? frame_mem[r-1][c] : '0;
        frame_mem[r][c] = W'(pv);
        last_d1 = v.e_d1; last_d2 = v.e_d2; last_d3 = v.e_d3;
        last_chk3 = v.chk3; last_chk12 = v.chk12;
        vecs.push_back(v);
    endfunction

    // Idle cycle: flags drop, data outputs hold.
    function automatic void add_idle(input bit sof);
        vec_t v;
        v.rst = 1'b0; v.sof = sof; v.valid = 1'b0; v.pix = W'(32'hABCDEF);
        v.e_valid = 1'b0; v.e_eol = 1'b0; v.e_eof = 1'b0;
        v.chk3 = last_chk3; v.chk12 = last_chk12;
        v.e_d1 = last_d1; v.e_d2 = last_d2; v.e_d3 = last_d3;
        vecs.push_back(v);
    endfunction

    // Reset with a live pixel: everything clears, pixel is dropped.
    function automatic void add_rst(input int pv);
        vec_t v;
        v.rst = 1'b1; v.sof = 1'b0; v.valid = 1'b1; v.pix = W'(pv);
        v.e_valid = 1'b0; v.e_eol = 1'b0; v.e_eof = 1'b0;
        v.chk3 = 1'b1; v.chk12 = 1'b1;
        v.e_d1 = '0; v.e_d2 = '0; v.e_d3 = '0;
        last_d1 = '0; last_d2 = '0; last_d3 = '0;
        last_chk3 = 1'b1; last_chk12 = 1'b1;
        vecs.push_back(v);
    endfunction

    function automatic void add_frame();
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++)
                add_pix(1'b0, r, c, r * 16 + c);
    endfunction

    task automatic check(input string name, input int vi, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec%0d: got %0h expected %0h", name, vi, act, exp);
    endtask

    initial begin
        // Frame 1: continuous stream.
        add_frame();
        // Frame 2: rows 0-1 continuous, row 2 with gaps, row 3 continuous.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < PW; c++) add_pix(1'b0, r, c, r * 16 + c);
        for (int c = 0; c < PW; c++) begin
            add_pix(1'b0, 2, c, 32 + c);
            add_idle(1'b0);
        end
        for (int c = 0; c < PW; c++) add_pix(1'b0, 3, c, 48 + c);
        // Frame 3: abandoned at row 2 col 1 by sof with a valid pixel.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < PW; c++) add_pix(1'b0, r, c, r * 16 + c);
        add_pix(1'b0, 2, 0, 'h20);
        add_pix(1'b1, 0, 0, 'h21);
        for (int k = 1; k < PW * PH; k++) add_pix(1'b0, k / PW, k % PW, (k / PW) * 16 + k % PW);
        // Frame 4: sof without a pixel mid-frame restarts the counters.
        for (int k = 0; k < 6; k++) add_pix(1'b0, k / PW, k % PW, 'h40 + k);
        add_idle(1'b1);
        add_frame();
        // Frame 5: reset at row 3 col 2, then a clean frame.
        for (int k = 0; k < 14; k++) add_pix(1'b0, k / PW, k % PW, (k / PW) * 16 + k % PW);
        add_rst('h32);
        add_frame();
        add_idle(1'b0);

        // Power-up reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_out", -1, W'(valid_out), '0);
        check("reset_eol_out",   -1, W'(eol_out),   '0);
        check("reset_eof_out",   -1, W'(eof_out),   '0);
        check("reset_dout1",     -1, dout1, '0);
        check("reset_dout2",     -1, dout2, '0);
        check("reset_dout3",     -1, dout3, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            sof_in   = vecs[i].sof;
            valid_in = vecs[i].valid;
            pixel_in = vecs[i].pix;
            @(posedge clk);
            #1;
            $display("vec%0d rst=%0b sof=%0b vin=%0b pix=%0h -> vout=%0b eol=%0b eof=%0b d1=%0h d2=%0h d3=%0h",
                     i, vecs[i].rst, vecs[i].sof, vecs[i].valid, vecs[i].pix,
                     valid_out, eol_out, eof_out, dout1, dout2, dout3);
            check("valid_out", i, W'(valid_out), W'(vecs[i].e_valid));
            check("eol_out",   i, W'(eol_out),   W'(vecs[i].e_eol));
            check("eof_out",   i, W'(eof_out),   W'(vecs[i].e_eof));
            if (vecs[i].chk3) check("dout3", i, dout3, vecs[i].e_d3);
            if (vecs[i].chk12) begin
                check("dout1", i, dout1, vecs[i].e_d1);
                check("dout2", i, dout2, vecs[i].e_d2);
            end
        end

        @(negedge clk);
        rst = 1'b0; sof_in = 1'b0; valid_in = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_line_buffer.md
Name: matrix_line_buffer

Overview:
- Producer side of the 3x3 window interface: takes a raster pixel stream and emits three vertically aligned rows per pixel (dout1 = row r-2, dout2 = row r-1, dout3 = row r).
- Feeds the din1/din2/din3/valid_in inputs of the 3x3 matrix operators (prewitt, sobel, etc.).
- Two internal line memories hold the previous two rows.
- Output valid is gated so that downstream sees only complete 3-row columns.

Parameters:
- WIDTH, 24, pixel width in bits (grey value in [7:0]).
- PIC_WIDTH, 480, pixels per row (2..511).
- PIC_HEIGHT, 272, rows per frame (3..511).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, one clock; reset is synchronous and active-high.
- sof_in  in  1  start of frame; clears column/row counters.
- valid_in  in  1  pixel_in valid this cycle.
- pixel_in  in  WIDTH  input pixel, raster order.
- dout1  out  WIDTH  pixel of row r-2, same column.
- dout2  out  WIDTH  pixel of row r-1, same column.
- dout3  out  WIDTH  pixel of row r (delayed pixel_in).
- valid_out  out  1  dout1..3 form a valid column.
- eol_out  out  1  with valid_out: column is PIC_WIDTH-1.
- eof_out  out  1  one-cycle pulse after the last pixel of the frame is accepted.

Behaviour:
- Reset (rst=1 at clk edge):
  - col_cnt, row_cnt = 0.
  - dout1..3 = 0; valid_out, eol_out, eof_out = 0.
  - Line memories are not cleared; stale contents are masked by row gating.
- Counters advance only on valid_in:
  - col_cnt 0..PIC_WIDTH-1, then wraps to 0 and row_cnt increments.
  - row_cnt 0..PIC_HEIGHT-1; wrapping past the last pixel of row PIC_HEIGHT-1 sets both counters to 0.
  - valid_in=0: all state holds and valid_out/eol_out/eof_out drop to 0. Outputs keep their values.
- Datapath, on an accepted pixel at column c (read-before-write, same cycle):
  - dout3 <= pixel_in; dout2 <= lineB[c]; dout1 <= lineA[c].
  - lineA[c] <= lineB[c]; lineB[c] <= pixel_in.
- Latency: exactly 1 clk from accepted pixel to outputs.
  - valid_out <= valid_in && (row_cnt >= 2), using row_cnt before the increment.
  - eol_out <= same condition && col_cnt == PIC_WIDTH-1.
- eof_out <= valid_in && col_cnt == PIC_WIDTH-1 && row_cnt == PIC_HEIGHT-1. It fires regardless of the row>=2 gate (always true at that point).
- sof_in handling:
  - sof_in=1 with valid_in=1: the pixel is taken as row 0, col 0 (counters behave as if they were 0 beforehand); col_cnt becomes 1.
  - sof_in=1 with valid_in=0: counters go to 0, no output.
  - sof_in mid-frame: abandons the frame. No eof_out. Outputs gated until 2 new rows are buffered.
- Rows 0 and 1 produce no valid_out. Each frame yields (PIC_HEIGHT-2)*PIC_WIDTH valid columns.
- Horizontal borders are the downstream block's concern; this block emits every column of rows 2..PIC_HEIGHT-1.
- Reset mid-frame: identical to a power-up reset. The next accepted pixel is row 0, col 0.
- Counters are 9-bit; no arithmetic overflow within parameter range.

Decomposition:
- Shared package: WIDTH and PIC_WIDTH/PIC_HEIGHT defaults, and a counter width constant of 9. These are shared with the matrix_3x3 operators.
- One sub-module, line_ram:
  - Single-port, depth PIC_WIDTH, width WIDTH.
  - Registered read with read-old-data on same-address write.
  - Instantiated twice (lineA, lineB).
- Counters and gating live in the top level.

Test Plan (bench PIC_WIDTH=4, PIC_HEIGHT=4, pixel_in = row*16+col, valid_in continuous):
- Rows 0-1 streamed -> valid_out stays 0 for the first 8 accepted pixels. Eighth pixel (0x13) is followed by no output pulse.
- Row 2, col 0 (0x20) accepted -> next cycle valid_out=1, dout1=0x00, dout2=0x10, dout3=0x20. Col 3 gives dout1=0x03, dout2=0x13, dout3=0x23 with eol_out=1.
- Last pixel 0x33 accepted -> next cycle dout1=0x13, dout2=0x23, dout3=0x33, eol_out=1, eof_out=1 for one cycle. The following pixel is treated as row 0 (valid_out=0).
- valid_in toggled 1/0 every cycle through row 2 -> valid_out pulses only after accepted pixels. The dout sequence is identical to the continuous case, and outputs hold during gaps.
- sof_in pulsed with pixel at row 2, col 1 -> that pixel is row 0, col 0. No valid_out for the next 8 accepted pixels; no eof_out for the abandoned frame.
- rst asserted one cycle at row 3, col 2 -> all outputs 0 next cycle. Restreaming a full frame reproduces the scenario 2/3 values exactly.
